// File: rtl/led_scan_pkg.sv
// Shared definitions for the LED scan controller: per-LED mode encoding,
// scan FSM state encoding and a width helper used for port and counter sizing.
package led_scan_pkg;

  localparam logic [1:0] LED_OFF  = 2'b00;
  localparam logic [1:0] LED_SLOW = 2'b01;
  localparam logic [1:0] LED_FAST = 2'b10;
  localparam logic [1:0] LED_ON   = 2'b11;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Bits needed to hold values 0..n-1; never less than one so that
  // degenerate sizes still produce a legal vector.
  function automatic int clogb2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_blink_gen.sv
// Blink reference generator: two free-running square waves whose periods are
// given in milliseconds and converted to clock cycles. Each wave is low for the
// first half of its period after reset and high for the second half.
module led_blink_gen
  import led_scan_pkg::*;
#(
  parameter int CLK_PERIOD_NS  = 10,
  parameter int SLOW_PERIOD_MS = 1000,
  parameter int FAST_PERIOD_MS = 100
) (
  input  logic clk,
  input  logic rst,
  output logic blink_slow,
  output logic blink_fast
);

  localparam int SLOW_CYC = int'(longint'(SLOW_PERIOD_MS) * 64'sd1000000 / longint'(CLK_PERIOD_NS));
  localparam int FAST_CYC = int'(longint'(FAST_PERIOD_MS) * 64'sd1000000 / longint'(CLK_PERIOD_NS));
  localparam int SLOW_W   = clogb2(SLOW_CYC);
  localparam int FAST_W   = clogb2(FAST_CYC);

  logic [SLOW_W-1:0] slow_cnt;
  logic [FAST_W-1:0] fast_cnt;

  // Slow period counter, wraps at the end of each period.
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_cnt <= '0;
    end else if (slow_cnt == SLOW_W'(SLOW_CYC - 1)) begin
      slow_cnt <= '0;
    end else begin
      slow_cnt <= slow_cnt + 1'b1;
    end
  end

  // Fast period counter, wraps at the end of each period.
  always_ff @(posedge clk) begin
    if (rst) begin
      fast_cnt <= '0;
    end else if (fast_cnt == FAST_W'(FAST_CYC - 1)) begin
      fast_cnt <= '0;
    end else begin
      fast_cnt <= fast_cnt + 1'b1;
    end
  end

  assign blink_slow = (slow_cnt >= SLOW_W'(SLOW_CYC / 2));
  assign blink_fast = (fast_cnt >= FAST_W'(FAST_CYC / 2));

endmodule

// File: rtl/led_scan_ctrl.sv
// Row-multiplexed LED matrix scan controller. Each LED has a 2-bit mode
// (off / slow blink / fast blink / on). Rows are driven one at a time for
// DWELL_CYCLES, separated by BLANK_CYCLES of dead time. All outputs are
// registered and computed from the FSM's next state so they line up with it.
// Optional feature: define LED_SCAN_BRIGHTNESS_EN to add a 4-bit global
// brightness input that gates the column drive with a free-running PWM.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int CLK_PERIOD_NS  = 10,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SLOW_PERIOD_MS = 1000,
  parameter int FAST_PERIOD_MS = 100,
  parameter int DWELL_CYCLES   = 25000,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [clogb2(ROWS*COLS)-1:0]    wr_addr,
  input  logic [1:0]                      wr_mode,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [3:0]                      brightness,
`endif
  output logic [COLS-1:0]                 scan_x,
  output logic [ROWS-1:0]                 scan_y,
  output logic                            frame_start
);

  localparam int LED_N = ROWS * COLS;
  localparam int AW    = clogb2(LED_N);
  localparam int RW    = clogb2(ROWS);
  localparam int CW    = clogb2((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES);

  logic [LED_N-1:0][1:0] mode_q;
  logic                  blink_slow;
  logic                  blink_fast;

  scan_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         row_q, row_d;

  logic [COLS-1:0]       lit_row;
  logic [COLS-1:0]       x_d;
  logic [ROWS-1:0]       y_d;
  logic                  fs_d;

  function automatic logic lit_state(input logic [1:0] m, input logic bs, input logic bf);
    logic r;
    case (m)
      LED_OFF:  r = 1'b0;
      LED_SLOW: r = bs;
      LED_FAST: r = bf;
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

  led_blink_gen #(
    .CLK_PERIOD_NS  (CLK_PERIOD_NS),
    .SLOW_PERIOD_MS (SLOW_PERIOD_MS),
    .FAST_PERIOD_MS (FAST_PERIOD_MS)
  ) u_blink (
    .clk        (clk),
    .rst        (rst),
    .blink_slow (blink_slow),
    .blink_fast (blink_fast)
  );

  // Per-LED mode storage; addresses past the last LED are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(LED_N))) begin
      mode_q[wr_addr] <= wr_mode;
    end
  end

  // Scan FSM state, dwell/blank cycle count and current row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic: count out blank time, then dwell time, then advance row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    row_d   = row_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm_q;

  // Free-running PWM phase for global dimming.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
    end
  end
`endif

  // Output decode for the upcoming cycle: row select, column drive, frame pulse.
  always_comb begin
    lit_row = '0;
    for (int i = 0; i < LED_N; i++) begin
      if (row_d == RW'(i / COLS)) begin
        lit_row[i % COLS] = lit_state(mode_q[i], blink_slow, blink_fast);
      end
    end
    x_d = '0;
    y_d = '1;
    if (state_d == ST_DRIVE) begin
      x_d        = lit_row;
      y_d[row_d] = 1'b0;
    end
`ifdef LED_SCAN_BRIGHTNESS_EN
    x_d = x_d & {COLS{pwm_q < brightness}};
`endif
    fs_d = (state_d == ST_DRIVE) && (state_q == ST_BLANK) && (row_d == '0);
  end

  // Registered outputs; reset forces the blank pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_x      <= '0;
      scan_y      <= '1;
      frame_start <= 1'b0;
    end else begin
      scan_x      <= x_d;
      scan_y      <= y_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl. Two instances share one write bus:
// a 4x4 matrix and a 3x3 matrix (the latter sees addresses 9..15 as out of
// range). Expected outputs come from a timeline model: cycle k since the last
// reset edge maps to frame position, row segment and blink/PWM phase.
// Build with LED_SCAN_BRIGHTNESS_EN defined to include brightness stimulus.
module tb_led_scan_ctrl;

  localparam int DW   = 100;
  localparam int BL   = 16;
  localparam int SEGL = DW + BL;
  localparam int SP   = 200;   // 2 ms at 10000 ns per cycle
  localparam int FP   = 100;   // 1 ms at 10000 ns per cycle

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [1:0] wr_mode;
  logic [3:0] x1, y1;
  logic [2:0] x2, y2;
  logic       f1, f2;
`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [3:0] brightness_in;
`endif

  int         bright = 16;     // 16 means "no dimming" in the model
  int         k = 0;
  int         last_fs = -1;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [1:0] m1 [16];
  logic [1:0] m2 [16];

  always #5 clk = ~clk;

  led_scan_ctrl #(
    .CLK_PERIOD_NS(10000), .ROWS(4), .COLS(4), .SLOW_PERIOD_MS(2), .FAST_PERIOD_MS(1),
    .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)
  ) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .brightness(brightness_in),
`endif
    .scan_x(x1), .scan_y(y1), .frame_start(f1)
  );

  led_scan_ctrl #(
    .CLK_PERIOD_NS(10000), .ROWS(3), .COLS(3), .SLOW_PERIOD_MS(2), .FAST_PERIOD_MS(1),
    .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)
  ) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .brightness(brightness_in),
`endif
    .scan_x(x2), .scan_y(y2), .frame_start(f2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", tag, k, got, exp);
    end
  endtask

  // Expected outputs at cycle k after the reset edge for a rows x cols matrix.
  function automatic void model(input int kk, input int rows, input int cols,
                                input logic [1:0] m [16], input int br,
                                output logic [31:0] ey, output logic [31:0] ex,
                                output logic [31:0] ef);
    int   p, seg, off;
    logic bs, bf, on;
    p   = kk % (rows * SEGL);
    seg = p / SEGL;
    off = p % SEGL;
    ey  = (32'd1 << rows) - 32'd1;
    ex  = '0;
    ef  = '0;
    if (off >= BL) begin
      ey[seg] = 1'b0;
      ef      = 32'((seg == 0) && (off == BL));
      bs      = ((kk - 1) % SP) >= (SP / 2);
      bf      = ((kk - 1) % FP) >= (FP / 2);
      for (int c = 0; c < cols; c++) begin
        case (m[seg * cols + c])
          2'b00:   on = 1'b0;
          2'b01:   on = bs;
          2'b10:   on = bf;
          default: on = 1'b1;
        endcase
        ex[c] = on;
      end
      if (((kk - 1) % 16) >= br) ex = '0;
    end
  endfunction

  // One clock: drive inputs, let the edge happen, compare, then update the model.
  task automatic step(input logic r, input logic we, input logic [3:0] a, input logic [1:0] md);
    logic [31:0] ey, ex, ef;
    rst     = r;
    wr_en   = we;
    wr_addr = a;
    wr_mode = md;
`ifdef LED_SCAN_BRIGHTNESS_EN
    brightness_in = 4'(bright);
`endif
    @(posedge clk);
    #1;
    if (r) begin
      k = 0;
      last_fs = -1;
    end else begin
      k++;
    end
    model(k, 4, 4, m1, bright, ey, ex, ef);
    check("d4_scan_y", 32'(y1), ey);
    check("d4_scan_x", 32'(x1), ex);
    check("d4_frame_start", 32'(f1), ef);
    model(k, 3, 3, m2, bright, ey, ex, ef);
    check("d3_scan_y", 32'(y2), ey);
    check("d3_scan_x", 32'(x2), ex);
    check("d3_frame_start", 32'(f2), ef);
    if (f1) begin
      if (last_fs >= 0) check("d4_frame_gap", 32'(k - last_fs), 32'd464);
      last_fs = k;
    end
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m1[i] = 2'b00;
        m2[i] = 2'b00;
      end
    end else if (we) begin
      m1[a] = md;
      if (a < 4'd9) m2[a] = md;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m1[i] = 2'b00;
      m2[i] = 2'b00;
    end
`ifdef LED_SCAN_BRIGHTNESS_EN
    bright = 15;
`endif
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_mode = '0;

    // Reset held two cycles, then a frame with everything off.
    step(1'b1, 1'b0, 4'd0, 2'b00);
    step(1'b1, 1'b0, 4'd0, 2'b00);
    idle(470);

    // Static on at LED 5 (row 1, col 1 of the 4x4; row 1, col 2 of the 3x3).
    step(1'b0, 1'b1, 4'd5, 2'b11);
    idle(480);

    // Slow blink on LED 0 right after reset, fast blink and an out-of-range-for-3x3 write.
    step(1'b1, 1'b0, 4'd0, 2'b00);
    step(1'b0, 1'b1, 4'd0, 2'b01);
    step(1'b0, 1'b1, 4'd10, 2'b10);
    step(1'b0, 1'b1, 4'd2, 2'b10);
    step(1'b0, 1'b1, 4'd12, 2'b11);
    idle(930);

    // Randomized writes, including mid-dwell writes to the active row.
    for (int i = 0; i < 2500; i++) begin
      step(1'b0, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end

    // Reset in the middle of row 2's dwell (bounded search).
    for (int i = 0; i < 500 && (k % 464) != (2 * SEGL + 50); i++) idle(1);
    check("reached_row2_dwell", 32'(k % 464), 32'(2 * SEGL + 50));
    step(1'b1, 1'b0, 4'd0, 2'b00);
    step(1'b0, 1'b1, 4'd0, 2'b11);
    idle(500);

`ifdef LED_SCAN_BRIGHTNESS_EN
    // Global dimming: 4/16 duty, dark, then near-full.
    bright = 4;
    step(1'b1, 1'b0, 4'd0, 2'b00);
    step(1'b0, 1'b1, 4'd0, 2'b11);
    idle(470);
    bright = 0;
    idle(470);
    bright = 15;
    idle(470);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
